// File: rtl/sprite_motion_if.sv
// Collision-checker link: walk/push directions out to the checker, bounce requests back.
// The master side is the motion controller, the slave side is the collision checker.
interface sprite_motion_if;
  logic left;
  logic right;
  logic up;
  logic down;
  logic bouncingLeft;
  logic bouncingRight;
  logic bouncingUp;
  logic bouncingDown;
  logic bounceLeft;
  logic bounceRight;
  logic bounceUp;
  logic bounceDown;

  modport master (
    output left, right, up, down,
    output bouncingLeft, bouncingRight, bouncingUp, bouncingDown,
    input  bounceLeft, bounceRight, bounceUp, bounceDown
  );

  modport slave (
    input  left, right, up, down,
    input  bouncingLeft, bouncingRight, bouncingUp, bouncingDown,
    output bounceLeft, bounceRight, bounceUp, bounceDown
  );
endinterface

// File: rtl/sprite_motion.sv
// Per-frame sprite motion controller feeding the map collision checker.
// Optional feature: define SPRITE_MOTION_RETRIGGER_EN to let a new push direction restart a bounce.
module sprite_motion #(
  parameter int unsigned X_INIT        = 320,
  parameter int unsigned Y_INIT        = 240,
  parameter int unsigned STEP          = 1,
  parameter int unsigned BOUNCE_FRAMES = 8,
  parameter int unsigned X_MAX         = 630,
  parameter int unsigned Y_MAX         = 470
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        frame_tick,
  input  logic        key_left,
  input  logic        key_right,
  input  logic        key_up,
  input  logic        key_down,
  output logic [19:0] spriteX,
  output logic [19:0] spriteY,
  output logic        busy,
  sprite_motion_if.master col
);

  typedef enum logic [1:0] {
    IDLE,
    MOVE,
    BOUNCE
  } stateT;

  // Direction vectors are ordered {down, up, right, left} so bit 0 has top priority.
  localparam logic [3:0] DIR_LEFT  = 4'b0001;
  localparam logic [3:0] DIR_RIGHT = 4'b0010;
  localparam logic [3:0] DIR_UP    = 4'b0100;
  localparam logic [3:0] DIR_DOWN  = 4'b1000;

  localparam logic [20:0] STEP_W  = 21'(STEP);
  localparam logic [20:0] X_MAX_W = 21'(X_MAX);
  localparam logic [20:0] Y_MAX_W = 21'(Y_MAX);

  stateT       state;
  stateT       stateNext;
  logic [19:0] xNext;
  logic [19:0] yNext;
  logic [3:0]  walkDir;
  logic [3:0]  walkNext;
  logic [3:0]  pushDir;
  logic [3:0]  pushNext;
  logic [7:0]  bounceCnt;
  logic [7:0]  cntNext;
  logic [3:0]  stepDir;
  logic        stepEn;
  logic        retrigger;

  logic [3:0]  keyVec;
  logic [3:0]  bounceVec;
  logic [3:0]  keyPri;
  logic [3:0]  bouncePri;

  function automatic logic [3:0] pickFirst(input logic [3:0] v);
    logic [3:0] r;
    r = 4'b0000;
    if (v[0])      r = DIR_LEFT;
    else if (v[1]) r = DIR_RIGHT;
    else if (v[2]) r = DIR_UP;
    else if (v[3]) r = DIR_DOWN;
    return r;
  endfunction

  function automatic logic [19:0] satSub(input logic [19:0] pos);
    logic [20:0] wide;
    wide = {1'b0, pos};
    if (wide < STEP_W) return 20'd0;
    return 20'(wide - STEP_W);
  endfunction

  function automatic logic [19:0] satAdd(input logic [19:0] pos, input logic [20:0] limit);
    logic [20:0] sum;
    sum = {1'b0, pos} + STEP_W;
    if (sum > limit) return 20'(limit);
    return 20'(sum);
  endfunction

  assign keyVec    = {key_down, key_up, key_right, key_left};
  assign bounceVec = {col.bounceDown, col.bounceUp, col.bounceRight, col.bounceLeft};
  assign keyPri    = pickFirst(keyVec);
  assign bouncePri = pickFirst(bounceVec);

`ifdef SPRITE_MOTION_RETRIGGER_EN
  assign retrigger = (bounceVec != 4'b0000) && (bouncePri != pushDir);
`else
  assign retrigger = 1'b0;
`endif

  // Next-state logic; nothing changes unless this cycle carries a frame tick.
  always_comb begin
    stateNext = state;
    walkNext  = walkDir;
    pushNext  = pushDir;
    cntNext   = bounceCnt;
    stepDir   = 4'b0000;
    stepEn    = 1'b0;
    if (frame_tick) begin
      case (state)
        IDLE, MOVE: begin
          if (bounceVec != 4'b0000) begin
            stateNext = BOUNCE;
            pushNext  = bouncePri;
            cntNext   = 8'(BOUNCE_FRAMES);
            walkNext  = 4'b0000;
          end else if (keyVec != 4'b0000) begin
            stateNext = MOVE;
            walkNext  = keyPri;
            stepDir   = keyPri;
            stepEn    = 1'b1;
          end else begin
            stateNext = IDLE;
            walkNext  = 4'b0000;
          end
        end
        BOUNCE: begin
          walkNext = 4'b0000;
          if (retrigger) begin
            pushNext = bouncePri;
            cntNext  = 8'(BOUNCE_FRAMES);
          end else begin
            stepDir = pushDir;
            stepEn  = 1'b1;
            cntNext = bounceCnt - 8'd1;
            if (bounceCnt == 8'd1) begin
              stateNext = IDLE;
              pushNext  = 4'b0000;
            end
          end
        end
        default: begin
          stateNext = IDLE;
          walkNext  = 4'b0000;
          pushNext  = 4'b0000;
          cntNext   = 8'd0;
        end
      endcase
    end
  end

  // Saturating one-step move along whichever direction the FSM chose.
  always_comb begin
    xNext = spriteX;
    yNext = spriteY;
    if (stepEn) begin
      case (stepDir)
        DIR_LEFT:  xNext = satSub(spriteX);
        DIR_RIGHT: xNext = satAdd(spriteX, X_MAX_W);
        DIR_UP:    yNext = satSub(spriteY);
        DIR_DOWN:  yNext = satAdd(spriteY, Y_MAX_W);
        default: begin
          xNext = spriteX;
          yNext = spriteY;
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state     <= IDLE;
      spriteX   <= 20'(X_INIT);
      spriteY   <= 20'(Y_INIT);
      walkDir   <= 4'b0000;
      pushDir   <= 4'b0000;
      bounceCnt <= 8'd0;
    end else begin
      state     <= stateNext;
      spriteX   <= xNext;
      spriteY   <= yNext;
      walkDir   <= walkNext;
      pushDir   <= pushNext;
      bounceCnt <= cntNext;
    end
  end

  assign busy               = (state == BOUNCE);
  assign col.left           = walkDir[0];
  assign col.right          = walkDir[1];
  assign col.up             = walkDir[2];
  assign col.down           = walkDir[3];
  assign col.bouncingLeft   = pushDir[0];
  assign col.bouncingRight  = pushDir[1];
  assign col.bouncingUp     = pushDir[2];
  assign col.bouncingDown   = pushDir[3];

endmodule

// File: tb/tb_sprite_motion.sv
// Self-checking bench for sprite_motion: directed scenarios plus random ticks, keys and bounces
// compared against a behavioural model of the motion rules.
module tb_sprite_motion;

  localparam int X_INIT = 320;
  localparam int Y_INIT = 240;
  localparam int STEP   = 1;
  localparam int BFR    = 8;
  localparam int X_MAX  = 630;
  localparam int Y_MAX  = 470;

  logic        Clk;
  logic        Reset_n;
  logic        frame_tick;
  logic        key_left, key_right, key_up, key_down;
  logic [19:0] spriteX, spriteY;
  logic        busy;

  sprite_motion_if colIf();

  sprite_motion dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .frame_tick (frame_tick),
    .key_left   (key_left),
    .key_right  (key_right),
    .key_up     (key_up),
    .key_down   (key_down),
    .spriteX    (spriteX),
    .spriteY    (spriteY),
    .busy       (busy),
    .col        (colIf)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int compareCount = 0;
  int errorCount   = 0;

  // Model state: direction indices 0=left 1=right 2=up 3=down, -1 = none.
  int mX, mY, mCnt, mWalk, mPush;
  bit mBouncing;

  function automatic int firstIdx(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic int oneHot(input int idx);
    return (idx < 0) ? 0 : (1 << idx);
  endfunction

  task automatic moveModel(input int dir);
    case (dir)
      0: mX = (mX < STEP) ? 0 : mX - STEP;
      1: mX = (mX + STEP > X_MAX) ? X_MAX : mX + STEP;
      2: mY = (mY < STEP) ? 0 : mY - STEP;
      3: mY = (mY + STEP > Y_MAX) ? Y_MAX : mY + STEP;
      default: ;
    endcase
  endtask

  task automatic modelStep(input bit tick, input logic [3:0] keys, input logic [3:0] bounces, input bit rstN);
    if (!rstN) begin
      mX = X_INIT; mY = Y_INIT; mCnt = 0; mWalk = -1; mPush = -1; mBouncing = 0;
    end else if (tick) begin
      if (!mBouncing) begin
        if (bounces != 0) begin
          mBouncing = 1; mPush = firstIdx(bounces); mCnt = BFR; mWalk = -1;
        end else if (keys != 0) begin
          mWalk = firstIdx(keys);
          moveModel(mWalk);
        end else begin
          mWalk = -1;
        end
      end else begin
`ifdef SPRITE_MOTION_RETRIGGER_EN
        if (bounces != 0 && firstIdx(bounces) != mPush) begin
          mPush = firstIdx(bounces); mCnt = BFR;
        end else begin
`else
        begin
`endif
          moveModel(mPush);
          mCnt = mCnt - 1;
          if (mCnt == 0) begin
            mBouncing = 0; mPush = -1;
          end
        end
      end
    end
  endtask

  task automatic checkOutput(input string tag, input int observed, input int expected);
    compareCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // One cycle: drive on the falling edge, update the model at the rising edge, check just after.
  task automatic applyStimulus(input bit tick, input logic [3:0] keys, input logic [3:0] bounces, input bit rstN);
    @(negedge Clk);
    Reset_n    = rstN;
    frame_tick = tick;
    {key_down, key_up, key_right, key_left} = keys;
    {colIf.bounceDown, colIf.bounceUp, colIf.bounceRight, colIf.bounceLeft} = bounces;
    @(posedge Clk);
    modelStep(tick, keys, bounces, rstN);
    #1;
    checkOutput("spriteX", int'(spriteX), mX);
    checkOutput("spriteY", int'(spriteY), mY);
    checkOutput("walk", int'({colIf.down, colIf.up, colIf.right, colIf.left}), oneHot(mWalk));
    checkOutput("push", int'({colIf.bouncingDown, colIf.bouncingUp, colIf.bouncingRight, colIf.bouncingLeft}), oneHot(mPush));
    checkOutput("busy", int'(busy), int'(mBouncing));
  endtask

  initial begin
    Reset_n = 1'b0; frame_tick = 1'b0;
    key_left = 0; key_right = 0; key_up = 0; key_down = 0;
    colIf.bounceLeft = 0; colIf.bounceRight = 0; colIf.bounceUp = 0; colIf.bounceDown = 0;
    mX = X_INIT; mY = Y_INIT; mCnt = 0; mWalk = -1; mPush = -1; mBouncing = 0;

    $display("[TB] reset");
    applyStimulus(0, 4'b0000, 4'b0000, 0);
    applyStimulus(0, 4'b0000, 4'b0000, 0);
    checkOutput("resetX", int'(spriteX), 320);
    checkOutput("resetY", int'(spriteY), 240);
    checkOutput("resetBusy", int'(busy), 0);

    $display("[TB] walk right");
    for (int i = 0; i < 5; i++) applyStimulus(1, 4'b0010, 4'b0000, 1);
    checkOutput("rightX", int'(spriteX), 325);
    checkOutput("rightFlag", int'(colIf.right), 1);
    applyStimulus(0, 4'b1111, 4'b1111, 1);
    checkOutput("glitchX", int'(spriteX), 325);
    applyStimulus(1, 4'b0000, 4'b0000, 1);
    checkOutput("idleRight", int'(colIf.right), 0);
    checkOutput("idleX", int'(spriteX), 325);

    $display("[TB] bounce right while walking left");
    for (int i = 0; i < 400 && mX > 100; i++) applyStimulus(1, 4'b0001, 4'b0000, 1);
    applyStimulus(1, 4'b0001, 4'b0010, 1);
    checkOutput("entryX", int'(spriteX), 100);
    checkOutput("entryPush", int'(colIf.bouncingRight), 1);
    checkOutput("entryBusy", int'(busy), 1);
    for (int i = 0; i < BFR; i++) applyStimulus(1, 4'b0001, 4'b0000, 1);
    checkOutput("bounceEndX", int'(spriteX), 108);
    checkOutput("bounceEndBusy", int'(busy), 0);

    $display("[TB] saturation");
    for (int i = 0; i < 400 && mX > 0; i++) applyStimulus(1, 4'b0001, 4'b0000, 1);
    for (int i = 0; i < 3; i++) applyStimulus(1, 4'b0001, 4'b0000, 1);
    checkOutput("satLeftX", int'(spriteX), 0);
    for (int i = 0; i < 400 && mY < Y_MAX; i++) applyStimulus(1, 4'b1000, 4'b0000, 1);
    applyStimulus(1, 4'b1000, 4'b0000, 1);
    checkOutput("satDownY", int'(spriteY), 470);

    $display("[TB] reset mid-bounce");
    applyStimulus(1, 4'b0000, 4'b1000, 1);
    for (int i = 0; i < 3; i++) applyStimulus(1, 4'b0000, 4'b0000, 1);
    checkOutput("satBounceY", int'(spriteY), 470);
    applyStimulus(1, 4'b0000, 4'b0000, 0);
    checkOutput("midResetX", int'(spriteX), 320);
    checkOutput("midResetY", int'(spriteY), 240);
    checkOutput("midResetBusy", int'(busy), 0);
    applyStimulus(1, 4'b0000, 4'b0000, 1);
    checkOutput("postResetX", int'(spriteX), 320);

    $display("[TB] retrigger");
    applyStimulus(1, 4'b0000, 4'b0010, 1);
    for (int i = 0; i < 3; i++) applyStimulus(1, 4'b0000, 4'b0000, 1);
    applyStimulus(1, 4'b0000, 4'b0001, 1);
`ifdef SPRITE_MOTION_RETRIGGER_EN
    checkOutput("retrigPush", int'(colIf.bouncingLeft), 1);
    checkOutput("retrigX", int'(spriteX), 323);
`else
    checkOutput("noRetrigPush", int'(colIf.bouncingRight), 1);
    checkOutput("noRetrigX", int'(spriteX), 324);
`endif
    for (int i = 0; i < BFR; i++) applyStimulus(1, 4'b0000, 4'b0000, 1);
    checkOutput("retrigDoneBusy", int'(busy), 0);

    $display("[TB] random");
    for (int i = 0; i < 1500; i++) begin
      bit         tick;
      bit         rstN;
      logic [3:0] keys;
      logic [3:0] bounces;
      tick    = ($urandom_range(0, 2) != 0);
      keys    = 4'($urandom_range(0, 15));
      bounces = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
      rstN    = ($urandom_range(0, 199) != 0);
      applyStimulus(tick, keys, bounces, rstN);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, errorCount);
    $finish;
  end

endmodule

// File: doc/sprite_motion.md
# sprite_motion

Per-frame sprite motion controller that sits directly upstream of the map collision checker. It owns the sprite's pixel position and produces the direction (`left/right/up/down`) and bounce-in-progress (`bouncingLeft/Right/Up/Down`) signals the collision checker consumes. It consumes the checker's `bounceLeft/Right/Up/Down` responses and runs a timed push-back when a wall is hit. Positions are pixels on a 640x480 screen, which maps to a 64x48 cell map of 10x10 px cells.

## Interface
- `X_INIT`, 320: reset X position (px)
- `Y_INIT`, 240: reset Y position (px)
- `STEP`, 1: pixels moved per frame, 1..15
- `BOUNCE_FRAMES`, 8: frames of push-back per bounce, 1..255
- `X_MAX`, 630: largest legal X (640 minus sprite width)
- `Y_MAX`, 470: largest legal Y (480 minus sprite height)

Ports:
- `Clk` in 1: system clock
- `Reset_n` in 1: synchronous, active-low reset
- `frame_tick` in 1: one-`Clk` pulse per video frame
- `key_left`, `key_right`, `key_up`, `key_down` in 1 each: held keyboard direction
- `bounceLeft`, `bounceRight`, `bounceUp`, `bounceDown` in 1 each: push direction requested by the collision checker
- `spriteX`, `spriteY` out 20: sprite top-left position (px)
- `left`, `right`, `up`, `down` out 1 each: one-hot current walk direction; all 0 when not walking
- `bouncingLeft`, `bouncingRight`, `bouncingUp`, `bouncingDown` out 1 each: one-hot current push direction; all 0 when not bouncing
- `busy` out 1: high while in BOUNCE

## Operation
- States: IDLE, MOVE, BOUNCE. All state advances only on cycles where `frame_tick` = 1. Cycles without `frame_tick` hold everything.
- IDLE/MOVE on a tick:
  - Any `bounce*` high: go to BOUNCE. Latch the push direction with priority Left > Right > Up > Down. Load counter = `BOUNCE_FRAMES`. Position unchanged on this tick.
  - Else any `key_*` high: go to MOVE. Direction priority is left > right > up > down. Move `STEP` px in that direction and set the one-hot walk output.
  - Else: go to IDLE, no move, walk outputs = 0.
- BOUNCE on a tick:
  - Move `STEP` px in the push direction and decrement the counter.
  - When the counter reaches 0 after the move, go to IDLE.
  - Keys are ignored in BOUNCE. Walk outputs are 0. Push output is one-hot.
- Push direction meaning: `bounceRight` means move +X; `bounceLeft` means -X; `bounceDown` means +Y; `bounceUp` means -Y.
- Arithmetic is 20-bit unsigned with saturation.
  - Subtract: if pos < `STEP`, pos becomes 0.
  - Add: if pos + `STEP` > `X_MAX` (or `Y_MAX`), pos becomes `X_MAX` (or `Y_MAX`).
  - Saturation does not end a bounce early.
- Reset values: `spriteX` = `X_INIT`, `spriteY` = `Y_INIT`, state IDLE, counter 0, all direction/bouncing outputs 0, `busy` 0.

## Timing
- All outputs are registered. Effects of a tick sampled at edge N are visible after edge N.
- `bounce*` and `key_*` are sampled only on the tick cycle. Glitches between ticks have no effect.
- Bounce length is exactly `BOUNCE_FRAMES` ticks after the entry tick. `busy` is high for entry tick + `BOUNCE_FRAMES` ticks.
- Bounce and key on the same tick: bounce wins.
- `Reset_n` low at any edge, including mid-bounce or coincident with `frame_tick`, forces the reset values at that edge. The tick is discarded.
- Back-to-back ticks on consecutive cycles are legal and each is processed.

## Configuration
- `SPRITE_MOTION_RETRIGGER_EN` defined:
  - In BOUNCE, a tick with any `bounce*` high whose priority direction differs from the current push direction reloads the counter to `BOUNCE_FRAMES` and switches direction.
  - No move occurs on that tick.
  - A same-direction request is ignored.
- Undefined: `bounce*` is ignored throughout BOUNCE.

## Test plan
- Reset (`Reset_n` = 0 for 2 cycles) -> `spriteX` = 320, `spriteY` = 240, all direction/bouncing outputs 0, `busy` = 0.
- `key_right` held for 5 ticks with no bounce -> `spriteX` = 325, `right` = 1 after the first tick. Release the key, then 1 tick -> IDLE, `right` = 0, X stays 325.
- `bounceRight` on a tick while walking left at X = 100 (with `BOUNCE_FRAMES` = 8) -> X = 100 on the entry tick, `bouncingRight` = 1, `busy` = 1. After 8 more ticks X = 108 and state is IDLE. `key_left` is ignored throughout.
- X = 0, `key_left` for 3 ticks -> X stays 0. Y = 470, `key_down` -> Y stays 470.
- `Reset_n` low during tick 4 of a bounce -> reset values at that edge. The next tick with no keys keeps the position.
- With the macro, a BOUNCE right followed by a `bounceLeft` tick at counter 5 -> `bouncingLeft` = 1, counter reloads to 8, X unchanged on that tick. Without the macro -> push right continues and ends after the original 8 ticks.
